pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register for the pipelined CPU datapath. It is the general replacement for the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB): an opaque payload bus of configurable width moves through a valid/ready handshake. The block supports back-pressure, a same-cycle flush for hazard and branch recovery, an optional skid entry for full throughput under stalls, and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_reg.sv | 151 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with an optional skid entry, a same-cycle flush
// and a saturating counter of back-pressured cycles.
module pipe_stage_reg #(
  parameter int DATA_WIDTH  = 69,
  parameter int SKID        = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLOCK,
  input  logic                   RESETn,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic [DATA_WIDTH-1:0]  In_Data,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [DATA_WIDTH-1:0]  Out_Data,
  input  logic                   Flush,
  input  logic                   CountClear,
  output logic [COUNT_WIDTH-1:0] StallCycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic in_fire;
  logic out_fire;

  assign in_fire  = In_Valid & In_Ready;
  assign out_fire = Out_Valid & Out_Ready;

  generate
    if (SKID != 0) begin : g_skid
      state_t                state_reg, state_next;
      logic [DATA_WIDTH-1:0] main_reg, main_next;
      logic [DATA_WIDTH-1:0] skid_reg, skid_next;
      logic                  ready_reg;

      // ready_reg tracks "skid entry free" one edge ahead, so In_Ready has no
      // combinational dependence on Out_Ready.
      always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
          state_reg <= EMPTY;
          main_reg  <= '0;
          skid_reg  <= '0;
          ready_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          main_reg  <= main_next;
          skid_reg  <= skid_next;
          ready_reg <= (state_next != FULL);
        end
      end

      always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (Flush) begin
          state_next = EMPTY;
        end else begin
          case (state_reg)
            EMPTY: begin
              if (in_fire) begin
                state_next = BUSY;
                main_next  = In_Data;
              end
            end
            BUSY: begin
              if (in_fire && out_fire) begin
                main_next = In_Data;
              end else if (in_fire) begin
                state_next = FULL;
                skid_next  = In_Data;
              end else if (out_fire) begin
                state_next = EMPTY;
              end
            end
            FULL: begin
              if (out_fire) begin
                state_next = BUSY;
                main_next  = skid_reg;
              end
            end
            default: state_next = EMPTY;
          endcase
        end
      end

      assign In_Ready  = ready_reg & ~Flush & RESETn;
      assign Out_Valid = (state_reg != EMPTY);
      assign Out_Data  = main_reg;
    end else begin : g_single
      state_t                state_reg, state_next;
      logic [DATA_WIDTH-1:0] main_reg, main_next;

      always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
          state_reg <= EMPTY;
          main_reg  <= '0;
        end else begin
          state_reg <= state_next;
          main_reg  <= main_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        if (Flush) begin
          state_next = EMPTY;
        end else if (in_fire) begin
          state_next = BUSY;
          main_next  = In_Data;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end

      // Single entry: accept whenever the held payload leaves this same cycle.
      assign In_Ready  = (~Out_Valid | Out_Ready) & ~Flush & RESETn;
      assign Out_Valid = (state_reg != EMPTY);
      assign Out_Data  = main_reg;
    end
  endgenerate

  logic [COUNT_WIDTH-1:0] stall_reg, stall_next;

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      stall_reg <= '0;
    end else begin
      stall_reg <= stall_next;
    end
  end

  always_comb begin
    stall_next = stall_reg;
    if (CountClear) begin
      stall_next = '0;
    end else if (Out_Valid && !Out_Ready && !Flush && (stall_reg != COUNT_MAX)) begin
      stall_next = stall_reg + 1'b1;
    end
  end

  assign StallCycles = stall_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector bench for pipe_stage_reg: one skid instance (2-bit counter) and
// one single-entry instance share the stimulus; each vector names the one it checks.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        count_clear;

  logic        a_ready, a_valid;
  logic [15:0] a_data;
  logic [1:0]  a_stall;
  logic        b_ready, b_valid;
  logic [15:0] b_data;
  logic [15:0] b_stall;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_WIDTH(16), .SKID(1), .COUNT_WIDTH(2)) u_skid (
    .CLOCK(clk), .RESETn(rst_n),
    .In_Valid(in_valid), .In_Ready(a_ready), .In_Data(in_data),
    .Out_Valid(a_valid), .Out_Ready(out_ready), .Out_Data(a_data),
    .Flush(flush), .CountClear(count_clear), .StallCycles(a_stall)
  );

  pipe_stage_reg #(.DATA_WIDTH(16), .SKID(0), .COUNT_WIDTH(16)) u_single (
    .CLOCK(clk), .RESETn(rst_n),
    .In_Valid(in_valid), .In_Ready(b_ready), .In_Data(in_data),
    .Out_Valid(b_valid), .Out_Ready(out_ready), .Out_Data(b_data),
    .Flush(flush), .CountClear(count_clear), .StallCycles(b_stall)
  );

  typedef struct {
    string       name;
    bit          rst;
    bit          sel;
    bit          iv;
    logic [15:0] id;
    bit          ordy;
    bit          fl;
    bit          clr;
    bit          exp_ready;
    bit          exp_valid;
    logic [15:0] exp_data;
    int          exp_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, bit rst, bit sel, bit iv, logic [15:0] id,
                              bit ordy, bit fl, bit clr, bit er, bit ev,
                              logic [15:0] ed, int es);
    vec_t v;
    v.name = name; v.rst = rst; v.sel = sel; v.iv = iv; v.id = id;
    v.ordy = ordy; v.fl = fl; v.clr = clr; v.exp_ready = er;
    v.exp_valid = ev; v.exp_data = ed; v.exp_stall = es;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0; count_clear = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic act_ready, act_valid;
    logic [15:0] act_data;
    logic [31:0] act_stall;

    // Streaming through the skid stage
    for (int k = 1; k <= 8; k++)
      add("stream", k == 1, 0, 1, 16'(k), 1, 0, 0, 1, 1, 16'(k), 0);
    add("stream_end", 0, 0, 0, 16'h0, 1, 0, 0, 1, 0, 16'h0, 0);
    // Back-pressure into FULL, then drain in order
    add("bp_A",     1, 0, 1, 16'hA, 0, 0, 0, 1, 1, 16'hA, 0);
    add("bp_B",     0, 0, 1, 16'hB, 0, 0, 0, 1, 1, 16'hA, 1);
    add("bp_C_blk", 0, 0, 1, 16'hC, 0, 0, 0, 0, 1, 16'hA, 2);
    add("bp_C_blk", 0, 0, 1, 16'hC, 0, 0, 0, 0, 1, 16'hA, 3);
    add("bp_drain", 0, 0, 1, 16'hC, 1, 0, 0, 0, 1, 16'hB, 3);
    add("bp_C",     0, 0, 1, 16'hC, 1, 0, 0, 1, 1, 16'hC, 3);
    add("bp_end",   0, 0, 0, 16'h0, 1, 0, 0, 1, 0, 16'h0, 3);
    // Flush while FULL, D offered in the flush cycle is refused
    add("fl_A",   1, 0, 1, 16'hA, 0, 0, 0, 1, 1, 16'hA, 0);
    add("fl_B",   0, 0, 1, 16'hB, 0, 0, 0, 1, 1, 16'hA, 1);
    add("fl_D",   0, 0, 1, 16'hD, 0, 1, 0, 0, 0, 16'h0, 1);
    add("fl_E",   0, 0, 1, 16'hE, 1, 0, 0, 1, 1, 16'hE, 1);
    add("fl_end", 0, 0, 0, 16'h0, 1, 0, 0, 1, 0, 16'h0, 1);
    // Counter saturation at 3 and clear during a stall
    add("sat_A", 1, 0, 1, 16'h5, 0, 0, 0, 1, 1, 16'h5, 0);
    add("sat_1", 0, 0, 0, 16'h0, 0, 0, 0, 1, 1, 16'h5, 1);
    add("sat_2", 0, 0, 0, 16'h0, 0, 0, 0, 1, 1, 16'h5, 2);
    add("sat_3", 0, 0, 0, 16'h0, 0, 0, 0, 1, 1, 16'h5, 3);
    add("sat_4", 0, 0, 0, 16'h0, 0, 0, 0, 1, 1, 16'h5, 3);
    add("sat_5", 0, 0, 0, 16'h0, 0, 0, 0, 1, 1, 16'h5, 3);
    add("sat_6", 0, 0, 0, 16'h0, 0, 0, 0, 1, 1, 16'h5, 3);
    add("sat_clr",   0, 0, 0, 16'h0, 0, 0, 1, 1, 1, 16'h5, 0);
    add("sat_after", 0, 0, 0, 16'h0, 0, 0, 0, 1, 1, 16'h5, 1);
    // Single-entry stage with Out_Ready toggling
    add("s0_1",    1, 1, 1, 16'h1, 1, 0, 0, 1, 1, 16'h1, 0);
    add("s0_2blk", 0, 1, 1, 16'h2, 0, 0, 0, 0, 1, 16'h1, 1);
    add("s0_2",    0, 1, 1, 16'h2, 1, 0, 0, 1, 1, 16'h2, 1);
    add("s0_3blk", 0, 1, 1, 16'h3, 0, 0, 0, 0, 1, 16'h2, 2);
    add("s0_3",    0, 1, 1, 16'h3, 1, 0, 0, 1, 1, 16'h3, 2);
    add("s0_end",  0, 1, 0, 16'h0, 1, 0, 0, 1, 0, 16'h0, 2);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
      flush = v.fl; count_clear = v.clr;
      #1;
      act_ready = v.sel ? b_ready : a_ready;
      check({v.name, "_in_ready"}, 32'(act_ready), 32'(v.exp_ready));
      @(posedge clk); #1;
      act_valid = v.sel ? b_valid : a_valid;
      act_data  = v.sel ? b_data : a_data;
      act_stall = v.sel ? 32'(b_stall) : 32'(a_stall);
      check({v.name, "_out_valid"}, 32'(act_valid), 32'(v.exp_valid));
      if (v.exp_valid) check({v.name, "_out_data"}, 32'(act_data), 32'(v.exp_data));
      check({v.name, "_stall"}, act_stall, 32'(v.exp_stall));
      $display("vec %0d %s: in_ready=%0b out_valid=%0b out_data=%h stall=%0d",
               i, v.name, act_ready, act_valid, act_data, act_stall);
    end

    // Asynchronous reset between edges while the skid stage is FULL
    do_reset();
    in_valid = 1'b1; in_data = 16'h11; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 16'h22;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("arst_pre_valid", 32'(a_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_valid), 32'd0);
    check("arst_data",  32'(a_data),  32'd0);
    check("arst_stall", 32'(a_stall), 32'd0);
    check("arst_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    check("arst_ready_held", 32'(a_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_ready_release", 32'(a_ready), 32'd1);
    check("arst_valid_release", 32'(a_valid), 32'd0);
    $display("seq arst: out_valid=%0b out_data=%h in_ready=%0b", a_valid, a_data, a_ready);

    // Single-entry In_Ready follows Out_Ready combinationally while full
    do_reset();
    in_valid = 1'b1; in_data = 16'h55; out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = 16'h66; out_ready = 1'b0; #1;
    check("comb_ready_lo", 32'(b_ready), 32'd0);
    out_ready = 1'b1; #1;
    check("comb_ready_hi", 32'(b_ready), 32'd1);
    flush = 1'b1; #1;
    check("comb_ready_flush", 32'(b_ready), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("comb_hold_data", 32'(b_data), 32'h55);
    $display("seq comb: out_valid=%0b out_data=%h", b_valid, b_data);

    // Flush wins over a simultaneous output transfer in the skid stage
    do_reset();
    in_valid = 1'b1; in_data = 16'h77; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 16'h88; out_ready = 1'b1; flush = 1'b1; #1;
    check("flout_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    check("flout_valid", 32'(a_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("flout_nocap", 32'(a_valid), 32'd0);
    $display("seq flush_out: out_valid=%0b in_ready=%0b", a_valid, a_ready);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
